// File: rtl/cursor_ctrl.sv
// Grid cursor controller: four synchronised, debounced direction buttons drive a cell position.
// A captured move is applied only on frame_tick so the renderer never sees a mid-frame change.
module cursor_ctrl #(
    parameter int GRID_N     = 4,
    parameter int CELL_PITCH = 32,
    parameter int ORIGIN_X   = 256,
    parameter int ORIGIN_Y   = 176,
    parameter int DB_CYCLES  = 1000000,
    parameter int WRAP       = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       frame_tick,
    output logic [9:0] top_left_x,
    output logic [9:0] top_left_y,
    output logic [3:0] cell_row,
    output logic [3:0] cell_col,
    output logic       moved
);

    localparam int IDX_W = $clog2(GRID_N);
    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(GRID_N - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [9:0]       ORG_X    = 10'(ORIGIN_X);
    localparam logic [9:0]       ORG_Y    = 10'(ORIGIN_Y);
    localparam logic [9:0]       PITCH    = 10'(CELL_PITCH);

    // The whole cursor box at the far cell must stay inside the 10-bit pixel space.
    if ((GRID_N < 2) || (GRID_N > 16) || (CELL_PITCH < 32) || (DB_CYCLES < 1) ||
        (ORIGIN_X + (GRID_N - 1) * CELL_PITCH + 31 > 1023) ||
        (ORIGIN_Y + (GRID_N - 1) * CELL_PITCH + 31 > 1023)) begin : g_param_check
        $error("cursor_ctrl: parameter set places the cursor outside the 10-bit pixel range");
    end

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;
    typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_t;

    logic [3:0]       btn_raw_s;
    logic [3:0]       sync1_r;
    logic [3:0]       sync2_r;
    logic [3:0]       db_r;
    logic [3:0]       db_d_r;
    logic [CNT_W-1:0] cnt_r [0:3];
    logic [3:0]       press_s;

    state_t           state_r;
    state_t           state_nx_s;
    dir_t             dir_r;
    dir_t             dir_nx_s;
    logic             apply_s;
    logic             changed_s;

    logic [IDX_W-1:0] row_r;
    logic [IDX_W-1:0] col_r;
    logic [IDX_W-1:0] row_nx_s;
    logic [IDX_W-1:0] col_nx_s;
    logic [9:0]       x_r;
    logic [9:0]       y_r;
    logic             moved_r;

    // Bit order doubles as priority order: lowest index wins.
    assign btn_raw_s = {btn_right, btn_left, btn_down, btn_up};
    assign press_s   = db_r & ~db_d_r;

    // Two-stage synchroniser plus per-button stability counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
            db_r    <= 4'b0000;
            db_d_r  <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
            db_d_r  <= db_r;
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] == db_r[i]) begin
                    cnt_r[i] <= CNT_ZERO;
                end else if (cnt_r[i] == CNT_LAST) begin
                    cnt_r[i] <= CNT_ZERO;
                    db_r[i]  <= sync2_r[i];
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Pending-move state and captured direction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            dir_r   <= DIR_UP;
        end else begin
            state_r <= state_nx_s;
            dir_r   <= dir_nx_s;
        end
    end

    // Capture one press while idle; release it to the position logic on frame_tick.
    always_comb begin
        state_nx_s = state_r;
        dir_nx_s   = dir_r;
        apply_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (press_s != 4'b0000) begin
                    state_nx_s = ST_PEND;
                    if (press_s[0]) begin
                        dir_nx_s = DIR_UP;
                    end else if (press_s[1]) begin
                        dir_nx_s = DIR_DOWN;
                    end else if (press_s[2]) begin
                        dir_nx_s = DIR_LEFT;
                    end else begin
                        dir_nx_s = DIR_RIGHT;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (frame_tick) begin
                    state_nx_s = ST_IDLE;
                    apply_s    = 1'b1;
                end else begin
                    state_nx_s = ST_PEND;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Target cell for the captured direction, wrapping or saturating at the edges.
    always_comb begin
        row_nx_s = row_r;
        col_nx_s = col_r;
        case (dir_r)
            DIR_UP: begin
                if (row_r != IDX_ZERO) begin
                    row_nx_s = row_r - IDX_ONE;
                end else if (WRAP != 0) begin
                    row_nx_s = IDX_MAX;
                end else begin
                    row_nx_s = row_r;
                end
            end
            DIR_DOWN: begin
                if (row_r != IDX_MAX) begin
                    row_nx_s = row_r + IDX_ONE;
                end else if (WRAP != 0) begin
                    row_nx_s = IDX_ZERO;
                end else begin
                    row_nx_s = row_r;
                end
            end
            DIR_LEFT: begin
                if (col_r != IDX_ZERO) begin
                    col_nx_s = col_r - IDX_ONE;
                end else if (WRAP != 0) begin
                    col_nx_s = IDX_MAX;
                end else begin
                    col_nx_s = col_r;
                end
            end
            DIR_RIGHT: begin
                if (col_r != IDX_MAX) begin
                    col_nx_s = col_r + IDX_ONE;
                end else if (WRAP != 0) begin
                    col_nx_s = IDX_ZERO;
                end else begin
                    col_nx_s = col_r;
                end
            end
            default: begin
                row_nx_s = row_r;
                col_nx_s = col_r;
            end
        endcase
        changed_s = apply_s && ((row_nx_s != row_r) || (col_nx_s != col_r));
    end

    // Cell indices and pixel coordinates update together on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_r   <= IDX_ZERO;
            col_r   <= IDX_ZERO;
            x_r     <= ORG_X;
            y_r     <= ORG_Y;
            moved_r <= 1'b0;
        end else begin
            moved_r <= changed_s;
            if (apply_s) begin
                row_r <= row_nx_s;
                col_r <= col_nx_s;
                x_r   <= ORG_X + 10'(col_nx_s) * PITCH;
                y_r   <= ORG_Y + 10'(row_nx_s) * PITCH;
            end else begin
                row_r <= row_r;
                col_r <= col_r;
                x_r   <= x_r;
                y_r   <= y_r;
            end
        end
    end

    assign top_left_x = x_r;
    assign top_left_y = y_r;
    assign cell_row   = 4'(row_r);
    assign cell_col   = 4'(col_r);
    assign moved      = moved_r;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Bench for cursor_ctrl: a wrapping and a saturating instance share directed stimulus and are
// checked every cycle against a behavioural model, plus hand-computed spot values.
`timescale 1ns/1ps
module tb_cursor_ctrl;

    localparam int DB    = 4;
    localparam int N     = 4;
    localparam int PITCH = 32;
    localparam int OX    = 256;
    localparam int OY    = 176;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic b_up = 1'b0, b_down = 1'b0, b_left = 1'b0, b_right = 1'b0, tick = 1'b0;

    logic [9:0] x_w, y_w, x_s, y_s;
    logic [3:0] r_w, c_w, r_s, c_s;
    logic       mv_w, mv_s;

    int n_cmp = 0;
    int n_bad = 0;
    int mv_cnt_w = 0;
    int mv_cnt_s = 0;
    int snap;

    always #5 clk = ~clk;

    cursor_ctrl #(.GRID_N(N), .CELL_PITCH(PITCH), .ORIGIN_X(OX), .ORIGIN_Y(OY),
                  .DB_CYCLES(DB), .WRAP(1)) dut_w (
        .clk(clk), .reset(reset), .btn_up(b_up), .btn_down(b_down), .btn_left(b_left),
        .btn_right(b_right), .frame_tick(tick), .top_left_x(x_w), .top_left_y(y_w),
        .cell_row(r_w), .cell_col(c_w), .moved(mv_w));

    cursor_ctrl #(.GRID_N(N), .CELL_PITCH(PITCH), .ORIGIN_X(OX), .ORIGIN_Y(OY),
                  .DB_CYCLES(DB), .WRAP(0)) dut_s (
        .clk(clk), .reset(reset), .btn_up(b_up), .btn_down(b_down), .btn_left(b_left),
        .btn_right(b_right), .frame_tick(tick), .top_left_x(x_s), .top_left_y(y_s),
        .cell_row(r_s), .cell_col(c_s), .moved(mv_s));

    // Model state. Index 0 of the position arrays = saturating instance, 1 = wrapping.
    int m_s1[4], m_s2[4], m_prev[4], m_run[4], m_db[4];
    bit m_evt[4];
    bit m_pend;
    int m_dir;
    int m_row[2], m_col[2];
    bit m_moved[2];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int step(input int v, input int delta, input bit wrap);
        int nv;
        nv = v + delta;
        if (nv < 0 || nv >= N) nv = wrap ? (nv + N) % N : v;
        return nv;
    endfunction

    // Behavioural model: a level is accepted once the synchronised input has held it for DB cycles.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int d = 0; d < 4; d++) begin
                    m_s1[d] = 0; m_s2[d] = 0; m_prev[d] = 0; m_run[d] = 0; m_db[d] = 0; m_evt[d] = 0;
                end
                m_pend = 0; m_dir = 0;
                for (int w = 0; w < 2; w++) begin
                    m_row[w] = 0; m_col[w] = 0; m_moved[w] = 0;
                end
            end else begin
                int raw[4];
                bit found;
                raw[0] = int'(b_up); raw[1] = int'(b_down); raw[2] = int'(b_left); raw[3] = int'(b_right);
                m_moved[0] = 0; m_moved[1] = 0;
                if (m_pend && tick) begin
                    for (int w = 0; w < 2; w++) begin
                        int nr, nc;
                        nr = m_row[w]; nc = m_col[w];
                        case (m_dir)
                            0: nr = step(m_row[w], -1, w == 1);
                            1: nr = step(m_row[w], 1, w == 1);
                            2: nc = step(m_col[w], -1, w == 1);
                            default: nc = step(m_col[w], 1, w == 1);
                        endcase
                        m_moved[w] = (nr != m_row[w]) || (nc != m_col[w]);
                        m_row[w] = nr; m_col[w] = nc;
                    end
                    m_pend = 0;
                end else if (!m_pend) begin
                    found = 0;
                    for (int d = 0; d < 4; d++) begin
                        if (m_evt[d] && !found) begin
                            found = 1; m_pend = 1; m_dir = d;
                        end
                    end
                end
                for (int d = 0; d < 4; d++) begin
                    m_evt[d] = 0;
                    if (m_s2[d] == m_prev[d]) begin
                        if (m_run[d] < 1000) m_run[d]++;
                    end else begin
                        m_run[d] = 1;
                    end
                    m_prev[d] = m_s2[d];
                    if (m_run[d] >= DB && m_db[d] != m_s2[d]) begin
                        m_db[d] = m_s2[d];
                        m_evt[d] = (m_s2[d] == 1);
                    end
                    m_s2[d] = m_s1[d];
                    m_s1[d] = raw[d];
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk("w_x", int'(x_w), OX + m_col[1] * PITCH);
            chk("w_y", int'(y_w), OY + m_row[1] * PITCH);
            chk("w_row", int'(r_w), m_row[1]);
            chk("w_col", int'(c_w), m_col[1]);
            chk("w_moved", int'(mv_w), int'(m_moved[1]));
            chk("s_x", int'(x_s), OX + m_col[0] * PITCH);
            chk("s_y", int'(y_s), OY + m_row[0] * PITCH);
            chk("s_row", int'(r_s), m_row[0]);
            chk("s_col", int'(c_s), m_col[0]);
            chk("s_moved", int'(mv_s), int'(m_moved[0]));
            if (mv_w) mv_cnt_w++;
            if (mv_s) mv_cnt_s++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int d, input logic v);
        case (d)
            0: b_up = v;
            1: b_down = v;
            2: b_left = v;
            default: b_right = v;
        endcase
    endtask

    task automatic press(input int d);
        set_btn(d, 1'b1); cyc(10);
        set_btn(d, 1'b0); cyc(8);
    endtask

    task automatic pulse_tick();
        tick = 1'b1; cyc(1);
        tick = 1'b0; cyc(3);
    endtask

    initial begin
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        chk("rst_x", int'(x_w), 256);
        chk("rst_y", int'(y_w), 176);
        chk("rst_row", int'(r_w), 0);
        chk("rst_col", int'(c_w), 0);
        chk("rst_moved", int'(mv_w), 0);
        repeat (3) pulse_tick();
        chk("idle_x", int'(x_w), 256);

        // Single right press, then a tick with nothing pending.
        snap = mv_cnt_w;
        press(3);
        pulse_tick();
        chk("right_col", int'(c_w), 1);
        chk("right_x", int'(x_w), 288);
        chk("right_moved_pulses", mv_cnt_w - snap, 1);
        pulse_tick();
        chk("right_hold_x", int'(x_w), 288);

        // Short glitches must not register; the stable press that follows moves exactly once.
        b_right = 1'b1; cyc(2); b_right = 1'b0; cyc(2);
        b_right = 1'b1; cyc(2); b_right = 1'b0; cyc(2);
        pulse_tick();
        chk("glitch_col", int'(c_w), 1);
        b_right = 1'b1; cyc(10); b_right = 1'b0; cyc(8);
        pulse_tick();
        pulse_tick();
        chk("bounce_col", int'(c_w), 2);

        // Left edge: wrap versus saturate.
        press(2); pulse_tick();
        press(2); pulse_tick();
        snap = mv_cnt_s;
        press(2); pulse_tick();
        chk("wrap_left_col", int'(c_w), 3);
        chk("wrap_left_x", int'(x_w), 352);
        chk("sat_left_col", int'(c_s), 0);
        chk("sat_left_moved", mv_cnt_s - snap, 0);

        // Bottom edge.
        repeat (3) begin press(1); pulse_tick(); end
        chk("down3_row_s", int'(r_s), 3);
        snap = mv_cnt_s;
        press(1); pulse_tick();
        chk("wrap_down_row", int'(r_w), 0);
        chk("sat_down_row", int'(r_s), 3);
        chk("sat_down_y", int'(y_s), 272);
        chk("sat_down_moved", mv_cnt_s - snap, 0);

        // Simultaneous up+left: up wins; a later press while pending is dropped.
        b_up = 1'b1; b_left = 1'b1; cyc(10);
        b_up = 1'b0; b_left = 1'b0; cyc(8);
        press(3);
        pulse_tick();
        chk("prio_row_w", int'(r_w), 3);
        chk("prio_col_w", int'(c_w), 3);
        chk("prio_row_s", int'(r_s), 2);
        pulse_tick();
        chk("drop_col_w", int'(c_w), 3);

        // Reset with a move pending and down still held.
        b_down = 1'b1; cyc(10);
        reset = 1'b1;
        #1;
        chk("mid_rst_x", int'(x_w), 256);
        chk("mid_rst_y", int'(y_w), 176);
        chk("mid_rst_col", int'(c_w), 0);
        cyc(2);
        reset = 1'b0;
        cyc(2);
        pulse_tick();
        chk("post_rst_early_row", int'(r_w), 0);
        cyc(2);
        pulse_tick();
        chk("post_rst_row_w", int'(r_w), 1);
        chk("post_rst_y_w", int'(y_w), 208);
        chk("post_rst_row_s", int'(r_s), 1);
        b_down = 1'b0; cyc(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
